// File: rtl/memory_interface_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package memory_interface_arbiter_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;

    // Fetches always read the whole word.
    localparam logic [3:0] FULL_FRAME_MASK = 4'b1111;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAccess  = 2'b01,
        StRespond = 2'b10
    } arb_state_e;

    typedef enum logic {
        GrantData  = 1'b0,
        GrantInstr = 1'b1
    } grant_e;

endpackage

// File: rtl/memory_interface_arbiter_if.sv
// Core-side request/response signals and backend memory signals of the arbiter.
// The tri-state port data buses are kept outside as plain ports.
interface memory_interface_arbiter_if;

    logic        instruction_memory_interface_enable;
    logic        instruction_memory_interface_state;
    logic [31:0] instruction_memory_interface_address;
    logic [3:0]  instruction_memory_interface_frame_mask;
    logic        instruction_memory_interface_ready;
    logic        instruction_memory_interface_error;

    logic        data_memory_interface_enable;
    logic        data_memory_interface_state;
    logic [31:0] data_memory_interface_address;
    logic [3:0]  data_memory_interface_frame_mask;
    logic        data_memory_interface_ready;
    logic        data_memory_interface_error;

    logic        mem_enable;
    logic        mem_state;
    logic [31:0] mem_address;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    // Arbiter view.
    modport slave (
        input  instruction_memory_interface_enable, instruction_memory_interface_state,
        input  instruction_memory_interface_address, instruction_memory_interface_frame_mask,
        output instruction_memory_interface_ready, instruction_memory_interface_error,
        input  data_memory_interface_enable, data_memory_interface_state,
        input  data_memory_interface_address, data_memory_interface_frame_mask,
        output data_memory_interface_ready, data_memory_interface_error,
        output mem_enable, mem_state, mem_address, mem_frame_mask, mem_write_data,
        input  mem_read_data, mem_ready
    );

    // Core and backend memory view.
    modport master (
        output instruction_memory_interface_enable, instruction_memory_interface_state,
        output instruction_memory_interface_address, instruction_memory_interface_frame_mask,
        input  instruction_memory_interface_ready, instruction_memory_interface_error,
        output data_memory_interface_enable, data_memory_interface_state,
        output data_memory_interface_address, data_memory_interface_frame_mask,
        input  data_memory_interface_ready, data_memory_interface_error,
        input  mem_enable, mem_state, mem_address, mem_frame_mask, mem_write_data,
        output mem_read_data, mem_ready
    );

endinterface

// File: rtl/arbiter_priority_select.sv
// Picks the winning port and the next data-streak value for the arbiter.
module arbiter_priority_select
    import memory_interface_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    localparam int unsigned StreakWidth = $clog2(MAX_DATA_STREAK + 1)
) (
    input  logic                   instr_enable,
    input  logic                   data_enable,
    input  logic [StreakWidth-1:0] streak,
    output logic                   grant_valid,
    output grant_e                 grant,
    output logic [StreakWidth-1:0] streak_next
);

    localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MAX_DATA_STREAK);

    // Data has priority unless it has already starved a waiting fetch for too long.
    always_comb begin
        grant_valid = instr_enable | data_enable;
        grant       = GrantData;
        streak_next = '0;
        if (data_enable && !(instr_enable && (streak == StreakMax))) begin
            grant = GrantData;
            if (instr_enable) begin
                streak_next = (streak == StreakMax) ? streak : streak + 1'b1;
            end
        end else if (instr_enable) begin
            grant = GrantInstr;
        end
    end

endmodule

// File: rtl/memory_interface_arbiter.sv
// Shares one single-port backing memory between instruction fetch and data load/store.
// One access at a time: IDLE (grant) -> ACCESS (wait backend) -> RESPOND (one-cycle ready).
module memory_interface_arbiter
    import memory_interface_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    memory_interface_arbiter_if.slave bus,
    output wire  [31:0]              instruction_memory_interface_data,
    inout  wire  [31:0]              data_memory_interface_data
);

    localparam int unsigned StreakWidth = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TimerWidth  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    grant_e                 grant_q, grant_d;
    logic [StreakWidth-1:0] streak_q, streak_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic                   mem_enable_q, mem_enable_d;
    logic                   mem_state_q, mem_state_d;
    logic [31:0]            mem_address_q, mem_address_d;
    logic [3:0]             mem_mask_q, mem_mask_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   error_q, error_d;

    logic                   grant_valid;
    grant_e                 grant;
    logic [StreakWidth-1:0] streak_next;
    logic                   respond_instr;
    logic                   respond_data;

    // The fetch port is read-only with a forced full mask, so these inputs carry nothing.
    logic unused_instr_fields;
    assign unused_instr_fields = ^{bus.instruction_memory_interface_state,
                                   bus.instruction_memory_interface_frame_mask};

    arbiter_priority_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_priority_select (
        .instr_enable(bus.instruction_memory_interface_enable),
        .data_enable (bus.data_memory_interface_enable),
        .streak      (streak_q),
        .grant_valid (grant_valid),
        .grant       (grant),
        .streak_next (streak_next)
    );

    // State, request and response registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= GrantData;
            streak_q      <= '0;
            timer_q       <= '0;
            mem_enable_q  <= DISABLE;
            mem_state_q   <= READ;
            mem_address_q <= '0;
            mem_mask_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            streak_q      <= streak_d;
            timer_q       <= timer_d;
            mem_enable_q  <= mem_enable_d;
            mem_state_q   <= mem_state_d;
            mem_address_q <= mem_address_d;
            mem_mask_q    <= mem_mask_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
        end
    end

    // Next-state: grant in IDLE, wait or time out in ACCESS, single RESPOND cycle.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        streak_d      = streak_q;
        timer_d       = timer_q;
        mem_enable_d  = mem_enable_q;
        mem_state_d   = mem_state_q;
        mem_address_d = mem_address_q;
        mem_mask_d    = mem_mask_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        error_d       = error_q;
        unique case (state_q)
            StIdle: begin
                streak_d = streak_next;
                timer_d  = '0;
                if (grant_valid) begin
                    grant_d      = grant;
                    error_d      = 1'b0;
                    mem_enable_d = ENABLE;
                    state_d      = StAccess;
                    if (grant == GrantInstr) begin
                        mem_state_d   = READ;
                        mem_address_d = bus.instruction_memory_interface_address;
                        mem_mask_d    = FULL_FRAME_MASK;
                        mem_wdata_d   = '0;
                    end else begin
                        mem_state_d   = bus.data_memory_interface_state;
                        mem_address_d = bus.data_memory_interface_address;
                        mem_mask_d    = bus.data_memory_interface_frame_mask;
                        mem_wdata_d   = (bus.data_memory_interface_state == WRITE) ?
                                        data_memory_interface_data : '0;
                    end
                end
            end
            StAccess: begin
                if (bus.mem_ready) begin
                    rdata_d      = bus.mem_read_data;
                    mem_enable_d = DISABLE;
                    state_d      = StRespond;
                end else if (timer_q == TimerLast) begin
                    rdata_d      = '0;
                    error_d      = 1'b1;
                    mem_enable_d = DISABLE;
                    state_d      = StRespond;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign respond_instr = (state_q == StRespond) && (grant_q == GrantInstr);
    assign respond_data  = (state_q == StRespond) && (grant_q == GrantData);

    assign bus.instruction_memory_interface_ready = respond_instr;
    assign bus.instruction_memory_interface_error = respond_instr & error_q;
    assign bus.data_memory_interface_ready        = respond_data;
    assign bus.data_memory_interface_error        = respond_data & error_q;

    assign bus.mem_enable     = mem_enable_q;
    assign bus.mem_state      = mem_state_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_frame_mask = mem_mask_q;
    assign bus.mem_write_data = mem_wdata_q;

    // Port buses are driven only in the respond cycle; the core owns the data bus otherwise.
    assign instruction_memory_interface_data = respond_instr ? rdata_q : 'z;
    assign data_memory_interface_data = (respond_data && (mem_state_q == READ)) ? rdata_q : 'z;

endmodule
